// File: rtl/fetch_sequencer.sv
// Purpose: sequences program load into instruction memory, then boots and steers the PC during a fetch run.
// Latency: state changes on the clock edge; write/PC strobes follow inputs combinationally in LOAD/RUN; load_done one cycle after the last word.
// Backpressure: host_ready is high throughout LOAD; host_valid gaps simply hold the load; stall holds the PC in RUN.
module fetch_sequencer #(
  parameter logic [31:0] BOOT_ADDR = 32'h0000_0000,
  parameter logic [31:0] ADDR_STEP = 32'd1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_start,
  input  logic [31:0] load_base,
  input  logic [15:0] load_count,
  input  logic        host_valid,
  input  logic [31:0] host_data,
  output logic        host_ready,
  input  logic        run_start,
  input  logic        halt_req,
  input  logic        stall,
  input  logic        branch_req,
  input  logic [31:0] branch_target,
  output logic        mem_load,
  output logic        writeEN,
  output logic [31:0] inst_mem_addr,
  output logic [31:0] writeData,
  output logic        cnt_en,
  output logic        pc_load_en,
  output logic [31:0] pc_load_val,
  output logic        busy,
  output logic        load_done,
  output logic [31:0] fetch_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    BOOT = 2'd2,
    RUN  = 2'd3
  } state_t;

  state_t      state;
  logic [31:0] addr_q;
  logic [15:0] remaining_q;
  logic        load_done_q;
  logic [31:0] fetch_count_q;

  // Reset low forces every strobe off in the reset cycle itself, so an
  // abort mid-LOAD or mid-RUN never leaks a write or a PC update.
  logic in_load;
  logic in_boot;
  logic in_run;

  assign in_load = rst && (state == LOAD);
  assign in_boot = rst && (state == BOOT);
  assign in_run  = rst && (state == RUN);

  // Control and datapath state: FSM, load address/count, done pulse, fetch counter.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= IDLE;
      addr_q        <= 32'd0;
      remaining_q   <= 16'd0;
      load_done_q   <= 1'b0;
      fetch_count_q <= 32'd0;
    end else begin
      load_done_q <= 1'b0;
      unique case (state)
        IDLE: begin
          // load_start has priority; a simultaneous run_start is dropped.
          if (load_start) begin
            if (load_count != 16'd0) begin
              state       <= LOAD;
              addr_q      <= load_base;
              remaining_q <= load_count;
            end else begin
              load_done_q <= 1'b1;
            end
          end else if (run_start) begin
            state         <= BOOT;
            fetch_count_q <= 32'd0;
          end
        end
        LOAD: begin
          // host_ready is constantly high here, so host_valid alone accepts a word.
          if (host_valid) begin
            addr_q      <= addr_q + ADDR_STEP;
            remaining_q <= remaining_q - 16'd1;
            if (remaining_q == 16'd1) begin
              state       <= IDLE;
              load_done_q <= 1'b1;
            end
          end
        end
        BOOT: begin
          state <= RUN;
        end
        RUN: begin
          if (halt_req) begin
            state <= IDLE;
          end else if (!branch_req && !stall) begin
            fetch_count_q <= fetch_count_q + 32'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Output decode: memory-load path in LOAD, PC control in BOOT/RUN, zeros elsewhere.
  always_comb begin
    mem_load      = 1'b0;
    host_ready    = 1'b0;
    writeEN       = 1'b0;
    inst_mem_addr = 32'd0;
    writeData     = 32'd0;
    cnt_en        = 1'b0;
    pc_load_en    = 1'b0;
    pc_load_val   = 32'd0;
    if (in_load) begin
      mem_load      = 1'b1;
      host_ready    = 1'b1;
      writeEN       = host_valid;
      inst_mem_addr = addr_q;
      writeData     = host_data;
    end else if (in_boot) begin
      pc_load_en  = 1'b1;
      pc_load_val = BOOT_ADDR;
    end else if (in_run) begin
      // halt > branch > stall > normal increment
      if (halt_req) begin
        cnt_en     = 1'b0;
        pc_load_en = 1'b0;
      end else if (branch_req) begin
        pc_load_en  = 1'b1;
        pc_load_val = branch_target;
      end else if (!stall) begin
        cnt_en = 1'b1;
      end
    end
  end

  assign busy        = (state != IDLE);
  assign load_done   = load_done_q;
  assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Purpose: self-checking bench for fetch_sequencer; expected memory writes go through a scoreboard queue.
// Latency: inputs driven 1ns after the rising edge, outputs sampled mid-cycle or at the falling edge.
// Backpressure: host_valid gaps and stall/branch/halt combinations are exercised directly.
module tb_fetch_sequencer;

  logic        clk;
  logic        rst;
  logic        load_start;
  logic [31:0] load_base;
  logic [15:0] load_count;
  logic        host_valid;
  logic [31:0] host_data;
  logic        host_ready;
  logic        run_start;
  logic        halt_req;
  logic        stall;
  logic        branch_req;
  logic [31:0] branch_target;
  logic        mem_load;
  logic        writeEN;
  logic [31:0] inst_mem_addr;
  logic [31:0] writeData;
  logic        cnt_en;
  logic        pc_load_en;
  logic [31:0] pc_load_val;
  logic        busy;
  logic        load_done;
  logic [31:0] fetch_count;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q[$];

  fetch_sequencer dut (
    .clk           (clk),
    .rst           (rst),
    .load_start    (load_start),
    .load_base     (load_base),
    .load_count    (load_count),
    .host_valid    (host_valid),
    .host_data     (host_data),
    .host_ready    (host_ready),
    .run_start     (run_start),
    .halt_req      (halt_req),
    .stall         (stall),
    .branch_req    (branch_req),
    .branch_target (branch_target),
    .mem_load      (mem_load),
    .writeEN       (writeEN),
    .inst_mem_addr (inst_mem_addr),
    .writeData     (writeData),
    .cnt_en        (cnt_en),
    .pc_load_en    (pc_load_en),
    .pc_load_val   (pc_load_val),
    .busy          (busy),
    .load_done     (load_done),
    .fetch_count   (fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic all_zero(input string tag);
    check({tag, "_mem_load"}, {31'd0, mem_load}, 32'd0);
    check({tag, "_host_ready"}, {31'd0, host_ready}, 32'd0);
    check({tag, "_writeEN"}, {31'd0, writeEN}, 32'd0);
    check({tag, "_addr"}, inst_mem_addr, 32'd0);
    check({tag, "_wdata"}, writeData, 32'd0);
    check({tag, "_cnt_en"}, {31'd0, cnt_en}, 32'd0);
    check({tag, "_pc_load_en"}, {31'd0, pc_load_en}, 32'd0);
    check({tag, "_pc_load_val"}, pc_load_val, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_load_done"}, {31'd0, load_done}, 32'd0);
  endtask

  // Issue a load command for one cycle; afterwards the DUT is in LOAD (count != 0).
  task automatic start_load(input logic [31:0] base, input logic [15:0] cnt);
    load_start = 1'b1;
    load_base  = base;
    load_count = cnt;
    cyc();
    load_start = 1'b0;
  endtask

  // Present one host word; the expected write is queued before the DUT can act on it.
  task automatic send_word(input logic [31:0] addr, input logic [31:0] data);
    host_valid = 1'b1;
    host_data  = data;
    exp_q.push_back('{addr: addr, data: data});
    cyc();
    host_valid = 1'b0;
  endtask

  // Write monitor plus the always-true output invariants.
  always @(negedge clk) begin
    if (writeEN) begin
      if (exp_q.size() == 0) begin
        check("wr_unexpected", inst_mem_addr, 32'hDEAD_DEAD);
      end else begin
        wr_t w;
        w = exp_q.pop_front();
        check("wr_addr", inst_mem_addr, w.addr);
        check("wr_data", writeData, w.data);
      end
    end
    if (cnt_en || pc_load_en) check("cnt_pc_excl", {31'd0, cnt_en & pc_load_en}, 32'd0);
    if (writeEN) check("wr_needs_mem_load", {31'd0, mem_load}, 32'd1);
  end

  initial begin
    rst = 1'b0;
    load_start = 1'b0;
    load_base = 32'd0;
    load_count = 16'd0;
    host_valid = 1'b0;
    host_data = 32'd0;
    run_start = 1'b0;
    halt_req = 1'b0;
    stall = 1'b0;
    branch_req = 1'b0;
    branch_target = 32'd0;
    cyc();
    cyc();
    all_zero("rst");
    check("rst_fetch_count", fetch_count, 32'd0);
    rst = 1'b1;
    cyc();

    // Three consecutive words at 0x10.
    start_load(32'h10, 16'd3);
    #1;
    check("ld_busy", {31'd0, busy}, 32'd1);
    check("ld_mem_load", {31'd0, mem_load}, 32'd1);
    check("ld_host_ready", {31'd0, host_ready}, 32'd1);
    check("ld_addr0", inst_mem_addr, 32'h10);
    send_word(32'h10, 32'hAAAA_0001);
    send_word(32'h11, 32'hBBBB_0002);
    check("ld_done_early", {31'd0, load_done}, 32'd0);
    send_word(32'h12, 32'hCCCC_0003);
    #1;
    check("ld_done", {31'd0, load_done}, 32'd1);
    check("ld_idle", {31'd0, busy}, 32'd0);
    check("ld_q_empty", exp_q.size(), 32'd0);
    cyc();
    check("ld_done_pulse", {31'd0, load_done}, 32'd0);

    // host_valid 1,0,0,1 for count=2.
    start_load(32'h20, 16'd2);
    send_word(32'h20, 32'h1111_2222);
    #1;
    check("gap_addr1", inst_mem_addr, 32'h21);
    check("gap_noen", {31'd0, writeEN}, 32'd0);
    cyc();
    check("gap_addr2", inst_mem_addr, 32'h21);
    cyc();
    check("gap_busy", {31'd0, busy}, 32'd1);
    send_word(32'h21, 32'h3333_4444);
    #1;
    check("gap_done", {31'd0, load_done}, 32'd1);
    check("gap_q_empty", exp_q.size(), 32'd0);
    cyc();

    // Address wrap at the top of the space.
    start_load(32'hFFFF_FFFF, 16'd2);
    send_word(32'hFFFF_FFFF, 32'h5555_6666);
    send_word(32'h0000_0000, 32'h7777_8888);
    #1;
    check("wrap_done", {31'd0, load_done}, 32'd1);
    check("wrap_q_empty", exp_q.size(), 32'd0);
    cyc();

    // Zero-length load: no LOAD state, done pulse next cycle.
    start_load(32'h30, 16'd0);
    #1;
    check("zero_busy", {31'd0, busy}, 32'd0);
    check("zero_done", {31'd0, load_done}, 32'd1);
    check("zero_mem_load", {31'd0, mem_load}, 32'd0);
    cyc();

    // load_start and run_start together: load wins.
    run_start = 1'b1;
    start_load(32'h38, 16'd1);
    run_start = 1'b0;
    #1;
    check("both_mem_load", {31'd0, mem_load}, 32'd1);
    check("both_no_pc", {31'd0, pc_load_en}, 32'd0);
    send_word(32'h38, 32'h9999_AAAA);
    #1;
    check("both_done", {31'd0, load_done}, 32'd1);
    check("both_fetch_count", fetch_count, 32'd0);
    cyc();

    // Run: boot, four increments, branch+stall, stall, halt+branch.
    run_start = 1'b1;
    cyc();
    run_start = 1'b0;
    #1;
    check("boot_pc_load_en", {31'd0, pc_load_en}, 32'd1);
    check("boot_pc_load_val", pc_load_val, 32'h0);
    check("boot_cnt_en", {31'd0, cnt_en}, 32'd0);
    check("boot_busy", {31'd0, busy}, 32'd1);
    cyc();
    for (int i = 0; i < 4; i++) begin
      #1;
      check("run_cnt_en", {31'd0, cnt_en}, 32'd1);
      cyc();
    end
    check("run_fetch_count", fetch_count, 32'd4);
    branch_req = 1'b1;
    stall = 1'b1;
    branch_target = 32'h0000_1234;
    #1;
    check("br_pc_load_en", {31'd0, pc_load_en}, 32'd1);
    check("br_pc_load_val", pc_load_val, 32'h0000_1234);
    check("br_cnt_en", {31'd0, cnt_en}, 32'd0);
    cyc();
    branch_req = 1'b0;
    check("br_fetch_count", fetch_count, 32'd4);
    #1;
    check("stall_cnt_en", {31'd0, cnt_en}, 32'd0);
    check("stall_pc_load_en", {31'd0, pc_load_en}, 32'd0);
    check("stall_pc_load_val", pc_load_val, 32'd0);
    cyc();
    stall = 1'b0;
    halt_req = 1'b1;
    branch_req = 1'b1;
    #1;
    check("halt_pc_load_en", {31'd0, pc_load_en}, 32'd0);
    check("halt_cnt_en", {31'd0, cnt_en}, 32'd0);
    cyc();
    halt_req = 1'b0;
    branch_req = 1'b0;
    #1;
    check("halt_busy", {31'd0, busy}, 32'd0);
    check("halt_fetch_count", fetch_count, 32'd4);

    // A new run clears the fetch counter.
    run_start = 1'b1;
    cyc();
    run_start = 1'b0;
    check("rerun_fetch_count", fetch_count, 32'd0);
    cyc();
    cyc();
    check("rerun_count1", fetch_count, 32'd1);

    // Reset mid-RUN: no PC strobe in the reset cycle.
    rst = 1'b0;
    branch_req = 1'b1;
    #1;
    check("rstrun_pc_load_en", {31'd0, pc_load_en}, 32'd0);
    check("rstrun_cnt_en", {31'd0, cnt_en}, 32'd0);
    cyc();
    rst = 1'b1;
    branch_req = 1'b0;
    #1;
    all_zero("rstrun");
    check("rstrun_fetch_count", fetch_count, 32'd0);
    cyc();

    // Reset during LOAD after one of three words.
    start_load(32'h40, 16'd3);
    send_word(32'h40, 32'hABCD_0001);
    rst = 1'b0;
    host_valid = 1'b1;
    host_data = 32'hABCD_0002;
    #1;
    check("rstld_writeEN", {31'd0, writeEN}, 32'd0);
    check("rstld_mem_load", {31'd0, mem_load}, 32'd0);
    cyc();
    rst = 1'b1;
    host_valid = 1'b0;
    #1;
    all_zero("rstld");
    cyc();
    check("rstld_no_done", {31'd0, load_done}, 32'd0);
    start_load(32'h50, 16'd1);
    send_word(32'h50, 32'hFEED_BEEF);
    #1;
    check("post_rst_done", {31'd0, load_done}, 32'd1);
    cyc();
    check("post_rst_idle", {31'd0, busy}, 32'd0);
    check("final_q_empty", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 Parameter BOOT_ADDR, default 32'h0000_0000, PC value loaded on entry to run.
REQ-002 Parameter ADDR_STEP, default 1, instruction-memory address increment per loaded word.
REQ-003 clk  in  1  single clock; all state changes on rising edge.
REQ-004 rst  in  1  synchronous, active-low reset.
REQ-005 load_start  in  1  request program load; sampled only in IDLE.
REQ-006 load_base  in  32  first load address; captured with load_start.
REQ-007 load_count  in  16  number of words to load; captured with load_start.
REQ-008 host_valid  in  1  host_data holds a word to write.
REQ-009 host_data  in  32  program word from host.
REQ-010 host_ready  out  1  sequencer accepts host_data this cycle.
REQ-011 run_start  in  1  request fetch run; sampled only in IDLE.
REQ-012 halt_req  in  1  stop fetching; return to IDLE.
REQ-013 stall  in  1  hold PC this cycle.
REQ-014 branch_req  in  1  redirect PC.
REQ-015 branch_target  in  32  redirect value.
REQ-016 mem_load  out  1  selects load address path of instruction memory.
REQ-017 writeEN  out  1  instruction-memory write strobe.
REQ-018 inst_mem_addr  out  32  load write address.
REQ-019 writeData  out  32  load write data.
REQ-020 cnt_en  out  1  program-counter increment enable.
REQ-021 pc_load_en  out  1  program-counter load strobe.
REQ-022 pc_load_val  out  32  program-counter load value.
REQ-023 busy  out  1  state is not IDLE.
REQ-024 load_done  out  1  one-cycle pulse on load completion.
REQ-025 fetch_count  out  32  count of cycles with cnt_en=1 since last run_start.

Function
REQ-026 FSM states SHALL be IDLE, LOAD, BOOT, RUN.
REQ-027 IDLE: load_start with load_count!=0 -> LOAD, capture base into address register, count into remaining register; load_start with load_count==0 -> stay IDLE, load_done=1 next cycle.
REQ-028 IDLE: load_start and run_start together -> load_start wins, run_start dropped.
REQ-029 IDLE: run_start alone -> BOOT, fetch_count cleared to 0.
REQ-030 LOAD: mem_load=1, host_ready=1; writeEN=host_valid (combinational), writeData=host_data, inst_mem_addr=address register.
REQ-031 LOAD: each accepted word (host_valid&host_ready) -> address += ADDR_STEP (mod 2^32, wraps 32'hFFFF_FFFF->0 for step 1), remaining -= 1.
REQ-032 LOAD: word accepted with remaining==1 -> IDLE, load_done=1 for exactly the following cycle; no further writes.
REQ-033 LOAD: host_valid=0 cycles -> no write, no address change, state held indefinitely.
REQ-034 LOAD: halt_req, run_start, branch_req, stall ignored.
REQ-035 BOOT: one cycle, pc_load_en=1, pc_load_val=BOOT_ADDR, cnt_en=0, then RUN unconditionally.
REQ-036 RUN priority: halt_req > branch_req > stall > normal.
REQ-037 RUN halt_req: cnt_en=0, pc_load_en=0, -> IDLE.
REQ-038 RUN branch_req: pc_load_en=1, pc_load_val=branch_target, cnt_en=0, stay RUN.
REQ-039 RUN stall only: cnt_en=0, pc_load_en=0.
REQ-040 RUN normal: cnt_en=1; fetch_count += 1 (wraps at 2^32).
REQ-041 Outside LOAD: mem_load, writeEN, host_ready = 0; outside BOOT/RUN: cnt_en, pc_load_en = 0.
REQ-042 pc_load_val SHALL be 0 when pc_load_en=0; writeData, inst_mem_addr SHALL be 0 outside LOAD.
REQ-043 cnt_en and pc_load_en SHALL never be 1 in the same cycle; writeEN SHALL never be 1 while mem_load=0.

Reset
REQ-044 rst=0 at a rising edge -> state IDLE; address, remaining, fetch_count = 0; all outputs 0 next cycle.
REQ-045 Reset mid-LOAD or mid-RUN aborts immediately; no load_done pulse, no write, no PC strobe in the reset cycle or after.

Verification
REQ-046 load_start, base=32'h10, count=3, host_valid steady, data A,B,C -> writes A@0x10, B@0x11, C@0x12, load_done 1 cycle after third write, then IDLE.
REQ-047 LOAD with host_valid toggling 1,0,0,1 for count=2 -> exactly 2 writes at base, base+1; address holds during gaps.
REQ-048 base=32'hFFFF_FFFF, count=2 -> writes at 0xFFFF_FFFF then 0x0000_0000.
REQ-049 run_start -> BOOT cycle pc_load_en=1, pc_load_val=0; then cnt_en=1 for 4 cycles -> fetch_count=4; branch_req+stall same cycle -> pc_load_en=1, cnt_en=0, fetch_count unchanged.
REQ-050 RUN with halt_req+branch_req same cycle -> no pc_load_en, state IDLE, busy=0 next cycle.
REQ-051 rst=0 during LOAD after 1 of 3 words -> IDLE, all outputs 0, no load_done; subsequent load_start count=1 completes normally.
